param_datapath: RTL and testbench

PARAM_DATAPATH -- requirements
Module: param_datapath

---
 rtl/param_datapath.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_param_datapath.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_datapath.sv
// ---------------------------------------------------------------------------
// param_datapath
//
// Parameterised single-bus CPU datapath: general register file, PC, IR, MAR,
// MDR, Y/Z ALU staging registers, a branch-condition flag, an output port and
// a small memory-handshake state machine with a timeout.
//
// Parameters
//   WIDTH        datapath width in bits (8..64)
//   NREGS        number of general registers (8 or 16)
//   MEM_TIMEOUT  cycles to wait in REQ for mem_ack before flagging an error
//
// Ports
//   clk, reset            clock (rising edge) and async active-low reset
//   bus_src, ba_out       bus source select; ba_out forces R0 to read as zero
//   reg_we, reg_sel       general register write from the bus
//   y_in .. out_in        load strobes for Y, Z (ALU result), IR, MAR, MDR,
//                         PC and the output port
//   alu_op                ALU operation (Y op bus)
//   inc_pc                PC <= PC + step (step = imm when con, else 1)
//   con_in, cond          capture branch condition evaluated on the bus
//   imm, in_port          immediate operand and input-port value
//   mem_rd, mem_wr        start a memory read / write
//   mem_req, mem_we       memory request and write qualifier
//   mem_addr, mem_wdata   memory address (MAR) and write data (MDR)
//   mem_rdata, mem_ack    memory read data and acknowledge
//   mem_busy, mem_done    transaction in progress / one-cycle completion
//   mem_err               sticky timeout flag, cleared by the next transaction
//   bus, ir, out_port     bus value, instruction register, output port
//   con                   branch condition flag
// ---------------------------------------------------------------------------
module param_datapath #(
   parameter int WIDTH       = 32,
   parameter int NREGS       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [4:0]               bus_src,
   input  logic                     ba_out,
   input  logic                     reg_we,
   input  logic [$clog2(NREGS)-1:0] reg_sel,
   input  logic                     y_in,
   input  logic                     z_in,
   input  logic                     ir_in,
   input  logic                     mar_in,
   input  logic                     mdr_in,
   input  logic                     pc_in,
   input  logic                     out_in,
   input  logic [3:0]               alu_op,
   input  logic                     inc_pc,
   input  logic                     con_in,
   input  logic [1:0]               cond,
   input  logic [WIDTH-1:0]         imm,
   input  logic [WIDTH-1:0]         in_port,
   input  logic                     mem_rd,
   input  logic                     mem_wr,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [WIDTH-1:0]         mem_addr,
   output logic [WIDTH-1:0]         mem_wdata,
   input  logic [WIDTH-1:0]         mem_rdata,
   input  logic                     mem_ack,
   output logic                     mem_busy,
   output logic                     mem_done,
   output logic                     mem_err,
   output logic [WIDTH-1:0]         bus,
   output logic [WIDTH-1:0]         ir,
   output logic [WIDTH-1:0]         out_port,
   output logic                     con
);

   localparam int SELW = $clog2(NREGS);
   localparam int SHW  = $clog2(WIDTH);
   // Last REQ cycle count value before the timeout fires.
   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic [WIDTH-1:0] mar_q, mar_d;
   logic [WIDTH-1:0] mdr_q, mdr_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             con_q, con_d;

   mem_state_e       state_q, state_d;
   logic             we_q, we_d;
   logic             err_q, err_d;
   logic [7:0]       timer_q, timer_d;

   logic [WIDTH-1:0]        busVal;
   logic [WIDTH-1:0]        aluRes;
   logic [WIDTH-1:0]        pcStep;
   logic signed [WIDTH-1:0] ySigned;
   logic [SHW-1:0]          shAmt;
   logic                    condRes;
   logic                    memActive;

   // Bus source decode. Codes below NREGS address the register file (R0 can
   // be forced to zero for base-address-free addressing); unassigned codes,
   // including register codes beyond NREGS, read as zero.
   always_comb begin
      busVal = '0;
      if (int'(bus_src) < NREGS) begin
         if (!(bus_src == 5'd0 && ba_out)) begin
            busVal = regs_q[bus_src[SELW-1:0]];
         end
      end else begin
         case (bus_src)
            5'd24:   busVal = pc_q;
            5'd25:   busVal = mdr_q;
            5'd26:   busVal = z_q;
            5'd27:   busVal = y_q;
            5'd28:   busVal = mar_q;
            5'd29:   busVal = in_port;
            5'd30:   busVal = imm;
            default: busVal = '0;
         endcase
      end
   end

   assign shAmt   = busVal[SHW-1:0];
   assign ySigned = y_q;

   // ALU: Y is the left operand, the bus the right operand. Shifts use only
   // the low log2(WIDTH) bus bits as the distance; undefined codes give zero.
   always_comb begin
      aluRes = '0;
      case (alu_op)
         4'd0:    aluRes = y_q + busVal;
         4'd1:    aluRes = y_q - busVal;
         4'd2:    aluRes = y_q & busVal;
         4'd3:    aluRes = y_q | busVal;
         4'd4:    aluRes = y_q ^ busVal;
         4'd5:    aluRes = ~busVal;
         4'd6:    aluRes = -busVal;
         4'd7:    aluRes = y_q << shAmt;
         4'd8:    aluRes = y_q >> shAmt;
         4'd9:    aluRes = ySigned >>> shAmt;
         default: aluRes = '0;
      endcase
   end

   // Branch condition evaluated on the current bus value.
   always_comb begin
      condRes = 1'b0;
      case (cond)
         2'd0:    condRes = (busVal == '0);
         2'd1:    condRes = (busVal != '0);
         2'd2:    condRes = ~busVal[WIDTH-1];
         default: condRes = busVal[WIDTH-1];
      endcase
   end

   assign pcStep    = con_q ? imm : {{(WIDTH-1){1'b0}}, 1'b1};
   assign memActive = (state_q == REQ);

   // Next-state for the datapath registers. MAR and MDR are frozen while a
   // memory request is outstanding so the memory sees stable address/data;
   // a read acknowledge is the only thing that may change MDR then.
   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      mar_d = mar_q;
      mdr_d = mdr_q;
      y_d   = y_q;
      z_d   = z_q;
      out_d = out_q;
      con_d = con_q;

      if (inc_pc) begin
         pc_d = pc_q + pcStep;
      end else if (pc_in) begin
         pc_d = busVal;
      end

      if (con_in) begin
         con_d = condRes;
      end else if (inc_pc) begin
         con_d = 1'b0;
      end

      if (ir_in)  ir_d  = busVal;
      if (y_in)   y_d   = busVal;
      if (z_in)   z_d   = aluRes;
      if (out_in) out_d = busVal;

      if (mar_in && !memActive) begin
         mar_d = busVal;
      end

      if (memActive && mem_ack && !we_q) begin
         mdr_d = mem_rdata;
      end else if (mdr_in && !memActive) begin
         mdr_d = busVal;
      end
   end

   // Memory handshake FSM. A new request is only accepted in IDLE; the
   // timeout counter counts REQ cycles and on expiry the transaction ends
   // through DONE with the sticky error set and MDR left untouched.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      err_d    = err_q;
      timer_d  = timer_q;
      mem_req  = 1'b0;
      mem_busy = 1'b0;
      mem_done = 1'b0;
      mem_we   = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_rd || mem_wr) begin
               state_d = REQ;
               we_d    = ~mem_rd;
               err_d   = 1'b0;
               timer_d = '0;
            end
         end
         REQ: begin
            mem_req  = 1'b1;
            mem_busy = 1'b1;
            mem_we   = we_q;
            if (mem_ack) begin
               state_d = DONE;
            end else if (timer_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         DONE: begin
            mem_done = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and FSM state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= '0;
         ir_q    <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         y_q     <= '0;
         z_q     <= '0;
         out_q   <= '0;
         con_q   <= 1'b0;
         state_q <= IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         timer_q <= '0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         y_q     <= y_d;
         z_q     <= z_d;
         out_q   <= out_d;
         con_q   <= con_d;
         state_q <= state_d;
         we_q    <= we_d;
         err_q   <= err_d;
         timer_q <= timer_d;
      end
   end

   // General register file, written from the bus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (reg_we) begin
         regs_q[reg_sel] <= busVal;
      end
   end

   assign bus       = busVal;
   assign ir        = ir_q;
   assign out_port  = out_q;
   assign con       = con_q;
   assign mem_addr  = mar_q;
   assign mem_wdata = mdr_q;
   assign mem_err   = err_q;

endmodule

// File: tb/tb_param_datapath.sv
module tb_param_datapath;

   localparam int WIDTH       = 32;
   localparam int NREGS       = 16;
   localparam int MEM_TIMEOUT = 15;

   localparam int S_BUS   = 0;
   localparam int S_CON   = 1;
   localparam int S_BUSY  = 2;
   localparam int S_REQ   = 3;
   localparam int S_DONE  = 4;
   localparam int S_ERR   = 5;
   localparam int S_IR    = 6;
   localparam int S_OUT   = 7;
   localparam int S_ADDR  = 8;
   localparam int S_WE    = 9;
   localparam int S_WDATA = 10;

   logic             clk;
   logic             reset;
   logic [4:0]       bus_src;
   logic             ba_out, reg_we;
   logic [3:0]       reg_sel;
   logic             y_in, z_in, ir_in, mar_in, mdr_in, pc_in, out_in;
   logic [3:0]       alu_op;
   logic             inc_pc, con_in;
   logic [1:0]       cond;
   logic [WIDTH-1:0] imm, in_port;
   logic             mem_rd, mem_wr;
   logic             mem_req, mem_we;
   logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
   logic             mem_ack, mem_busy, mem_done, mem_err;
   logic [WIDTH-1:0] bus, ir, out_port;
   logic             con;

   typedef struct {
      string       name;
      int          sel;
      logic [63:0] exp;
      int          due;
   } chk_t;

   typedef struct {
      logic [63:0] wdata;
      logic        err;
   } mem_exp_t;

   typedef struct {
      logic [31:0] y;
      logic [31:0] b;
      logic [3:0]  op;
      logic [31:0] exp;
   } alu_vec_t;

   chk_t     sbQ[$];
   mem_exp_t memQ[$];
   alu_vec_t aluTab[$];

   int negCount   = 0;
   int checkCount = 0;
   int passCount  = 0;

   param_datapath #(
      .WIDTH(WIDTH), .NREGS(NREGS), .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .bus_src(bus_src), .ba_out(ba_out),
      .reg_we(reg_we), .reg_sel(reg_sel), .y_in(y_in), .z_in(z_in),
      .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in), .pc_in(pc_in),
      .out_in(out_in), .alu_op(alu_op), .inc_pc(inc_pc), .con_in(con_in),
      .cond(cond), .imm(imm), .in_port(in_port), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .mem_busy(mem_busy), .mem_done(mem_done),
      .mem_err(mem_err), .bus(bus), .ir(ir), .out_port(out_port), .con(con)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] observe(input int sel);
      case (sel)
         S_BUS:   return 64'(bus);
         S_CON:   return 64'(con);
         S_BUSY:  return 64'(mem_busy);
         S_REQ:   return 64'(mem_req);
         S_DONE:  return 64'(mem_done);
         S_ERR:   return 64'(mem_err);
         S_IR:    return 64'(ir);
         S_OUT:   return 64'(out_port);
         S_ADDR:  return 64'(mem_addr);
         S_WE:    return 64'(mem_we);
         S_WDATA: return 64'(mem_wdata);
         default: return '0;
      endcase
   endfunction

   // Monitor: at every falling edge, compare all scoreboard entries due now;
   // whenever the DUT signals completion, compare against the next expected
   // memory transaction outcome.
   initial begin
      chk_t        c;
      mem_exp_t    m;
      logic [63:0] got;
      forever begin
         @(negedge clk);
         negCount++;
         while (sbQ.size() > 0 && sbQ[0].due <= negCount) begin
            c = sbQ.pop_front();
            checkCount++;
            got = observe(c.sel);
            if (c.due != negCount) begin
               $display("[TB] FAIL %s: sampled late at edge %0d, required edge %0d", c.name, negCount, c.due);
            end else if (got === c.exp) begin
               passCount++;
            end else begin
               $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", c.name, got, c.exp);
            end
         end
         if (mem_done === 1'b1) begin
            checkCount++;
            if (memQ.size() == 0) begin
               $display("[TB] FAIL mem_done: got unexpected completion, expected none");
            end else begin
               m = memQ.pop_front();
               if (64'(mem_wdata) === m.wdata && mem_err === m.err) begin
                  passCount++;
               end else begin
                  $display("[TB] FAIL mem_txn: got mdr=0x%0h err=%0b, expected mdr=0x%0h err=%0b",
                           mem_wdata, mem_err, m.wdata, m.err);
               end
            end
         end
      end
   end

   // Push an expectation for the next falling edge.
   task automatic checkOutput(input string name, input int sel, input logic [63:0] exp);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.exp  = exp;
      c.due  = negCount + 1;
      sbQ.push_back(c);
   endtask

   // Let pending expectations be sampled before inputs change again.
   task automatic holdForChecks();
      @(negedge clk);
      #1;
   endtask

   // One rising edge with the current inputs, then drop one-shot strobes.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      reg_we = 0; y_in = 0; z_in = 0; ir_in = 0; mar_in = 0; mdr_in = 0;
      pc_in = 0; out_in = 0; inc_pc = 0; con_in = 0; mem_rd = 0; mem_wr = 0;
      mem_ack = 0;
   endtask

   task automatic setReg(input logic [3:0] idx, input logic [31:0] val);
      bus_src = 5'd30;
      imm     = val;
      reg_sel = idx;
      reg_we  = 1;
      applyStimulus();
   endtask

   initial begin
      reset = 0; bus_src = 0; ba_out = 0; reg_we = 0; reg_sel = 0;
      y_in = 0; z_in = 0; ir_in = 0; mar_in = 0; mdr_in = 0; pc_in = 0;
      out_in = 0; alu_op = 0; inc_pc = 0; con_in = 0; cond = 0;
      imm = 0; in_port = 32'h0000_1111; mem_rd = 0; mem_wr = 0;
      mem_rdata = 0; mem_ack = 0;

      aluTab.push_back('{32'h5,        32'h7,       4'd0,  32'hC});
      aluTab.push_back('{32'h3,        32'h5,       4'd1,  32'hFFFF_FFFE});
      aluTab.push_back('{32'hF0F0,     32'hFF00,    4'd2,  32'hF000});
      aluTab.push_back('{32'hF0F0,     32'h0F0F,    4'd3,  32'hFFFF});
      aluTab.push_back('{32'hFF00,     32'h0FF0,    4'd4,  32'hF0F0});
      aluTab.push_back('{32'h7B,       32'h0,       4'd5,  32'hFFFF_FFFF});
      aluTab.push_back('{32'h99,       32'h2,       4'd6,  32'hFFFF_FFFE});
      aluTab.push_back('{32'h1,        32'h4,       4'd7,  32'h10});
      aluTab.push_back('{32'h1,        32'd33,      4'd7,  32'h2});
      aluTab.push_back('{32'h8000_0000, 32'd31,     4'd8,  32'h1});
      aluTab.push_back('{32'h8000_0000, 32'h4,      4'd9,  32'hF800_0000});
      aluTab.push_back('{32'h4000_0000, 32'h4,      4'd9,  32'h0400_0000});
      aluTab.push_back('{32'h5,        32'h7,       4'd12, 32'h0});

      // Reset state.
      applyStimulus();
      applyStimulus();
      checkOutput("rst_bus", S_BUS, 0);
      checkOutput("rst_con", S_CON, 0);
      checkOutput("rst_err", S_ERR, 0);
      checkOutput("rst_busy", S_BUSY, 0);
      checkOutput("rst_req", S_REQ, 0);
      checkOutput("rst_done", S_DONE, 0);
      checkOutput("rst_ir", S_IR, 0);
      checkOutput("rst_out", S_OUT, 0);
      checkOutput("rst_addr", S_ADDR, 0);
      holdForChecks();
      reset = 1;

      // Register file and ALU through Y/Z.
      setReg(4'd3, 32'd5);
      setReg(4'd4, 32'd7);
      bus_src = 5'd3; y_in = 1; applyStimulus();
      bus_src = 5'd4; alu_op = 4'd0; z_in = 1; applyStimulus();
      bus_src = 5'd26;
      checkOutput("z_add_regs", S_BUS, 32'd12);
      holdForChecks();
      setReg(4'd3, 32'd0);
      setReg(4'd4, 32'd1);
      bus_src = 5'd3; y_in = 1; applyStimulus();
      bus_src = 5'd4; alu_op = 4'd1; z_in = 1; applyStimulus();
      bus_src = 5'd26;
      checkOutput("z_sub_wrap", S_BUS, 32'hFFFF_FFFF);
      holdForChecks();

      foreach (aluTab[i]) begin
         bus_src = 5'd30; imm = aluTab[i].y; y_in = 1; applyStimulus();
         imm = aluTab[i].b; alu_op = aluTab[i].op; z_in = 1; applyStimulus();
         bus_src = 5'd26;
         checkOutput($sformatf("alu_vec%0d", i), S_BUS, 64'(aluTab[i].exp));
         holdForChecks();
      end

      // Several loads in one cycle.
      bus_src = 5'd30; imm = 32'hA5A5; ir_in = 1; out_in = 1; applyStimulus();
      checkOutput("multi_ir", S_IR, 32'hA5A5);
      checkOutput("multi_out", S_OUT, 32'hA5A5);
      holdForChecks();

      // Bus decode, BA and unused codes.
      setReg(4'd0, 32'd9);
      setReg(4'd15, 32'hBEEF);
      bus_src = 5'd0; ba_out = 0;
      checkOutput("r0_read", S_BUS, 32'd9);
      holdForChecks();
      ba_out = 1;
      checkOutput("r0_ba_zero", S_BUS, 0);
      holdForChecks();
      ba_out = 0; bus_src = 5'd31;
      checkOutput("src31_zero", S_BUS, 0);
      holdForChecks();
      bus_src = 5'd20;
      checkOutput("src20_zero", S_BUS, 0);
      holdForChecks();
      bus_src = 5'd15;
      checkOutput("r15_read", S_BUS, 32'hBEEF);
      holdForChecks();
      bus_src = 5'd29;
      checkOutput("in_port", S_BUS, 32'h1111);
      holdForChecks();

      // Branch condition and PC stepping.
      bus_src = 5'd30; imm = 32'h10; pc_in = 1; applyStimulus();
      bus_src = 5'd31; cond = 2'd0; con_in = 1; applyStimulus();
      checkOutput("con_set", S_CON, 1);
      holdForChecks();
      imm = 32'd4; inc_pc = 1; applyStimulus();
      bus_src = 5'd24;
      checkOutput("pc_imm_step", S_BUS, 32'h14);
      checkOutput("con_cleared", S_CON, 0);
      holdForChecks();
      inc_pc = 1; applyStimulus();
      checkOutput("pc_unit_step", S_BUS, 32'h15);
      holdForChecks();
      bus_src = 5'd30; imm = 32'h40; inc_pc = 1; pc_in = 1; applyStimulus();
      bus_src = 5'd24;
      checkOutput("pc_inc_priority", S_BUS, 32'h16);
      holdForChecks();
      bus_src = 5'd30; imm = 32'h8000_0000; cond = 2'd3; con_in = 1; applyStimulus();
      checkOutput("con_msb1", S_CON, 1);
      holdForChecks();
      cond = 2'd2; con_in = 1; applyStimulus();
      checkOutput("con_msb0", S_CON, 0);
      holdForChecks();

      // Memory read acknowledged in the third REQ cycle.
      bus_src = 5'd30; imm = 32'h20; mar_in = 1; applyStimulus();
      memQ.push_back('{64'hCAFE, 1'b0});
      mem_rd = 1; applyStimulus();
      checkOutput("rd_busy1", S_BUSY, 1);
      checkOutput("rd_req", S_REQ, 1);
      checkOutput("rd_we", S_WE, 0);
      checkOutput("rd_addr", S_ADDR, 32'h20);
      holdForChecks();
      imm = 32'h99; mar_in = 1; applyStimulus();
      checkOutput("rd_busy2", S_BUSY, 1);
      checkOutput("mar_frozen", S_ADDR, 32'h20);
      holdForChecks();
      applyStimulus();
      checkOutput("rd_busy3", S_BUSY, 1);
      holdForChecks();
      mem_ack = 1; mem_rdata = 32'hCAFE; applyStimulus();
      checkOutput("rd_done", S_DONE, 1);
      checkOutput("rd_busy_end", S_BUSY, 0);
      holdForChecks();
      applyStimulus();
      bus_src = 5'd25;
      checkOutput("rd_done_pulse", S_DONE, 0);
      checkOutput("rd_mdr", S_BUS, 32'hCAFE);
      holdForChecks();

      // Write with no acknowledge: timeout.
      memQ.push_back('{64'hCAFE, 1'b1});
      mem_wr = 1; applyStimulus();
      checkOutput("wr_we", S_WE, 1);
      checkOutput("wr_busy", S_BUSY, 1);
      checkOutput("wr_err_start", S_ERR, 0);
      holdForChecks();
      bus_src = 5'd30; imm = 32'h5555; mdr_in = 1; applyStimulus();
      for (int i = 0; i < MEM_TIMEOUT - 2; i++) begin
         applyStimulus();
      end
      checkOutput("wr_busy_last", S_BUSY, 1);
      checkOutput("wr_err_pending", S_ERR, 0);
      holdForChecks();
      applyStimulus();
      checkOutput("wr_timeout_err", S_ERR, 1);
      checkOutput("wr_timeout_done", S_DONE, 1);
      checkOutput("wr_timeout_idle", S_BUSY, 0);
      holdForChecks();
      applyStimulus();
      bus_src = 5'd25;
      checkOutput("err_sticky", S_ERR, 1);
      checkOutput("wr_mdr_kept", S_BUS, 32'hCAFE);
      holdForChecks();

      // Next read clears the error.
      memQ.push_back('{64'h1234, 1'b0});
      mem_rd = 1; mem_rdata = 32'h1234; applyStimulus();
      checkOutput("err_cleared", S_ERR, 0);
      checkOutput("rd2_we", S_WE, 0);
      holdForChecks();
      mem_ack = 1; applyStimulus();
      applyStimulus();

      // Reset in the middle of a transaction.
      bus_src = 5'd30; imm = 32'h8000_0000; cond = 2'd3; con_in = 1; applyStimulus();
      mem_rd = 1; applyStimulus();
      checkOutput("mid_req", S_REQ, 1);
      checkOutput("mid_con", S_CON, 1);
      holdForChecks();
      applyStimulus();
      reset = 0; bus_src = 5'd0; ba_out = 0;
      checkOutput("arst_req", S_REQ, 0);
      checkOutput("arst_busy", S_BUSY, 0);
      checkOutput("arst_we", S_WE, 0);
      checkOutput("arst_done", S_DONE, 0);
      checkOutput("arst_err", S_ERR, 0);
      checkOutput("arst_con", S_CON, 0);
      checkOutput("arst_ir", S_IR, 0);
      checkOutput("arst_out", S_OUT, 0);
      checkOutput("arst_addr", S_ADDR, 0);
      checkOutput("arst_wdata", S_WDATA, 0);
      checkOutput("arst_r0", S_BUS, 0);
      holdForChecks();
      applyStimulus();
      reset = 1;
      bus_src = 5'd15;
      checkOutput("arst_r15", S_BUS, 0);
      holdForChecks();
      applyStimulus();
      applyStimulus();

      checkCount++;
      if (sbQ.size() == 0 && memQ.size() == 0) begin
         passCount++;
      end else begin
         $display("[TB] FAIL drain: got %0d checks and %0d transactions outstanding, expected 0 and 0",
                  sbQ.size(), memQ.size());
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
